// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - multi-read-port register file with post-reset clear sweep
// Optional write-through forwarding: define REGFILE_BYPASS_EN.
module register_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [NUM_RD*ADDR_W-1:0] ReadRegister,
    input  logic [ADDR_W-1:0]        WriteRegister,
    input  logic [DATA_W-1:0]        WriteData,
    input  logic                     RegWrite,
    output logic [NUM_RD*DATA_W-1:0] ReadData,
    output logic                     Ready,
    output logic                     WriteDropped
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_clr_idx;
    logic [ADDR_W-1:0]   w_clr_idx_next;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_waddr;
    logic [DATA_W-1:0]   w_mem_wdata;
    logic                w_wr_zero;
    logic                w_wr_perform;
    logic                w_drop_next;
    logic                r_write_dropped;
    logic [ADDR_W-1:0]   w_raddr   [NUM_RD];
    logic [DATA_W-1:0]   w_rd_next [NUM_RD];
    logic [DATA_W-1:0]   r_rd_data [NUM_RD];

    assign w_wr_zero = (ZERO_REG != 0) && (WriteRegister == '0);

    // The clear sweep owns the single write port until it finishes.
    always_comb begin
        w_state_next   = r_state;
        w_clr_idx_next = r_clr_idx;
        w_mem_we       = 1'b0;
        w_mem_waddr    = WriteRegister;
        w_mem_wdata    = WriteData;
        w_wr_perform   = 1'b0;
        w_drop_next    = 1'b0;
        if (Rst) begin
            w_state_next   = ST_CLEAR;
            w_clr_idx_next = '0;
        end else if (r_state == ST_CLEAR) begin
            w_mem_we       = 1'b1;
            w_mem_waddr    = r_clr_idx;
            w_mem_wdata    = '0;
            w_clr_idx_next = r_clr_idx + ADDR_W'(1);
            w_drop_next    = RegWrite;
            if (r_clr_idx == {ADDR_W{1'b1}}) begin
                w_state_next = ST_RUN;
            end
        end else begin
            w_wr_perform = RegWrite && !w_wr_zero;
            w_mem_we     = w_wr_perform;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state         <= ST_CLEAR;
            r_clr_idx       <= '0;
            r_write_dropped <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_clr_idx       <= w_clr_idx_next;
            r_write_dropped <= w_drop_next;
        end
    end

    // Storage carries no reset; the sweep is what zeroes it.
    always_ff @(posedge Clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            w_raddr[p]   = ReadRegister[p*ADDR_W +: ADDR_W];
            w_rd_next[p] = r_mem[w_raddr[p]];
            if ((ZERO_REG != 0) && (w_raddr[p] == '0)) begin
                w_rd_next[p] = '0;
            end
`ifdef REGFILE_BYPASS_EN
            if (w_wr_perform && (w_raddr[p] == WriteRegister)) begin
                w_rd_next[p] = WriteData;
            end
`endif
            if (r_state == ST_CLEAR) begin
                w_rd_next[p] = '0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        for (int p = 0; p < NUM_RD; p++) begin
            if (Rst) begin
                r_rd_data[p] <= '0;
            end else begin
                r_rd_data[p] <= w_rd_next[p];
            end
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd_out
        assign ReadData[g*DATA_W +: DATA_W] = r_rd_data[g];
    end

    assign Ready        = (r_state == ST_RUN);
    assign WriteDropped = r_write_dropped;

endmodule

// File: tb/tb_register_file_mp.sv
// tb/tb_register_file_mp.sv - randomized self-checking bench for register_file_mp
module tb_register_file_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int DEPTH = 32;

    logic             Clk = 1'b0;
    logic             Rst;
    logic [NR*AW-1:0] ReadRegister;
    logic [AW-1:0]    WriteRegister;
    logic [DW-1:0]    WriteData;
    logic             RegWrite;
    logic [NR*DW-1:0] ReadData;
    logic             Ready;
    logic             WriteDropped;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] m_mem [DEPTH];
    int            sweep_left = DEPTH;
    logic [DW-1:0] exp_rd [NR];
    logic          exp_ready;
    logic          exp_drop;

    register_file_mp dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .ReadRegister (ReadRegister),
        .WriteRegister(WriteRegister),
        .WriteData    (WriteData),
        .RegWrite     (RegWrite),
        .ReadData     (ReadData),
        .Ready        (Ready),
        .WriteDropped (WriteDropped)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        logic [AW-1:0] ra;
        if (Rst) begin
            for (int p = 0; p < NR; p++) exp_rd[p] = '0;
            exp_drop   = 1'b0;
            sweep_left = DEPTH;
        end else if (sweep_left > 0) begin
            for (int p = 0; p < NR; p++) exp_rd[p] = '0;
            exp_drop   = RegWrite;
            sweep_left = sweep_left - 1;
            if (sweep_left == 0) begin
                for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            end
        end else begin
            exp_drop = 1'b0;
            for (int p = 0; p < NR; p++) begin
                ra = ReadRegister[p*AW +: AW];
                exp_rd[p] = (ra == 0) ? '0 : m_mem[ra];
`ifdef REGFILE_BYPASS_EN
                if (RegWrite && WriteRegister != 0 && ra == WriteRegister) exp_rd[p] = WriteData;
`endif
            end
            if (RegWrite && WriteRegister != 0) m_mem[WriteRegister] = WriteData;
        end
        exp_ready = (sweep_left == 0);
        @(posedge Clk);
        #1;
        for (int p = 0; p < NR; p++) begin
            total++;
            assert (ReadData[p*DW +: DW] === exp_rd[p]) else begin
                bad++;
                $error("FAIL rd%0d observed=%h expected=%h", p, ReadData[p*DW +: DW], exp_rd[p]);
            end
        end
        total++;
        assert (Ready === exp_ready) else begin
            bad++;
            $error("FAIL ready observed=%b expected=%b", Ready, exp_ready);
        end
        total++;
        assert (WriteDropped === exp_drop) else begin
            bad++;
            $error("FAIL drop observed=%b expected=%b", WriteDropped, exp_drop);
        end
    endtask

    task automatic rand_inputs(input int addr_hi);
        RegWrite      = 1'($urandom);
        WriteRegister = AW'($urandom_range(0, addr_hi));
        WriteData     = $urandom;
        for (int p = 0; p < NR; p++) ReadRegister[p*AW +: AW] = AW'($urandom_range(0, addr_hi));
    endtask

    initial begin
        int n;
        Rst = 1'b1; RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 32'h1111_2222;
        ReadRegister = '0;
        tick();
        tick();

        // Sweep after reset, with one write attempt that must be dropped.
        Rst = 1'b0; RegWrite = 1'b0;
        n = 0;
        while (!Ready && n < 64) begin
            ReadRegister = NR*AW'($urandom);
            if (n == 5) begin
                RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 32'hDEAD_BEEF;
            end else begin
                RegWrite = 1'b0;
            end
            tick();
            n++;
        end
        total++;
        assert (n == DEPTH) else begin
            bad++;
            $error("FAIL sweep_len observed=%0d expected=%0d", n, DEPTH);
        end

        RegWrite = 1'b0; ReadRegister = {5'd0, 5'd3};
        tick();
        total++;
        assert (ReadData[31:0] === 32'h0) else begin
            bad++;
            $error("FAIL addr3_after_drop observed=%h expected=%h", ReadData[31:0], 32'h0);
        end

        RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 32'h1234_5678;
        tick();
        RegWrite = 1'b0; ReadRegister = {5'd7, 5'd7};
        tick();
        total++;
        assert (ReadData === {32'h1234_5678, 32'h1234_5678}) else begin
            bad++;
            $error("FAIL addr7_both observed=%h expected=%h", ReadData, {32'h1234_5678, 32'h1234_5678});
        end

        RegWrite = 1'b1; WriteRegister = 5'd0; WriteData = 32'hFFFF_FFFF;
        tick();
        RegWrite = 1'b0; ReadRegister = {5'd0, 5'd0};
        tick();
        total++;
        assert (ReadData[31:0] === 32'h0 && WriteDropped === 1'b0) else begin
            bad++;
            $error("FAIL zero_reg observed=%h/%b expected=0/0", ReadData[31:0], WriteDropped);
        end

        RegWrite = 1'b1; WriteRegister = 5'd9; WriteData = 32'h1;
        tick();
        WriteData = 32'hA5A5_A5A5; ReadRegister = {5'd0, 5'd9};
        tick();
        total++;
`ifdef REGFILE_BYPASS_EN
        assert (ReadData[31:0] === 32'hA5A5_A5A5) else begin
            bad++;
            $error("FAIL same_edge observed=%h expected=%h", ReadData[31:0], 32'hA5A5_A5A5);
        end
`else
        assert (ReadData[31:0] === 32'h1) else begin
            bad++;
            $error("FAIL same_edge observed=%h expected=%h", ReadData[31:0], 32'h1);
        end
`endif
        RegWrite = 1'b0;
        tick();

        for (int i = 0; i < 400; i++) begin
            rand_inputs((i < 200) ? 7 : 31);
            tick();
        end

        // Reset in RUN, then again mid-sweep at clear index 10.
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rand_inputs(31);
            tick();
        end
        Rst = 1'b1;
        rand_inputs(31);
        tick();
        Rst = 1'b0;
        n = 0;
        while (!Ready && n < 64) begin
            rand_inputs(31);
            tick();
            n++;
        end
        total++;
        assert (n == DEPTH) else begin
            bad++;
            $error("FAIL resweep_len observed=%0d expected=%0d", n, DEPTH);
        end

        RegWrite = 1'b0;
        for (int i = 0; i < DEPTH / 2; i++) begin
            ReadRegister = {AW'(2*i+1), AW'(2*i)};
            tick();
        end

        for (int i = 0; i < 300; i++) begin
            rand_inputs(15);
            Rst = ($urandom_range(0, 59) == 0);
            tick();
        end
        Rst = 1'b0;
        RegWrite = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
